// File: rtl/hbus_pkg.sv
`default_nettype none
// ============================================================================
// hbus_pkg : shared HyperBus read-path types and constants     | rev 1.0
// ============================================================================
package hbus_pkg;

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        WAIT_FIRST = 5'b00010,
        CAPTURE    = 5'b00100,
        DONE       = 5'b01000,
        ERROR      = 5'b10000
    } hbus_state_e;

    // RWDS sample pair (rise, fall) that qualifies a DDR data word
    localparam logic [1:0] c_rwds_strobe = 2'b10;

    // A burst length field of zero encodes the maximum of 256 words
    function automatic logic [8:0] burst_words(input logic [7:0] len);
        return {(len == 8'd0), len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hbus_sync_fifo.sv
`default_nettype none
// ============================================================================
// hbus_sync_fifo : first-word-fall-through FIFO with flush     | rev 1.0
// ============================================================================
module hbus_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk90,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer MSB separates the full case from the empty case
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level = r_wptr - r_rptr;
    assign dout  = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk90) begin
        if (w_do_push && !flush)
            r_mem[r_wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hbus_rd_capture.sv
`default_nettype none
// ============================================================================
// hbus_rd_capture : HyperBus DDR read-burst capture into FIFO  | rev 1.0
// ============================================================================
module hbus_rd_capture
    import hbus_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 8,
    parameter int TIMEOUT_COUNT = 15
) (
    input  logic                     clk90,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [7:0]               burst_len_i,
    input  logic                     abort_i,
    input  logic [2*WIDTH-1:0]       dq_i,
    input  logic [1:0]               rwds_i,
    output logic [2*WIDTH-1:0]       dat_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o,
    output logic                     timeout_o
);
    localparam int TW = $clog2(TIMEOUT_COUNT + 1);

    hbus_state_e r_state;
    hbus_state_e w_state_nxt;
    logic [8:0]    r_wcnt;
    logic [TW-1:0] r_tcnt;
    logic          r_overflow;

    logic w_strobe;
    logic w_timed_out;
    logic w_arm;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_busy;

    assign w_strobe    = (rwds_i == c_rwds_strobe);
    assign w_timed_out = (r_tcnt == TW'(TIMEOUT_COUNT));
    assign w_busy      = (r_state == WAIT_FIRST) || (r_state == CAPTURE);
    assign w_pop       = valid_o && ready_i;

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        w_push      = 1'b0;
        if (abort_i) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE, ERROR: begin
                    if (start_i) begin
                        w_arm       = 1'b1;
                        w_state_nxt = WAIT_FIRST;
                    end
                end
                WAIT_FIRST, CAPTURE: begin
                    if (w_timed_out) begin
                        w_state_nxt = ERROR;
                    end else if (w_strobe) begin
                        w_push      = 1'b1;
                        w_state_nxt = (r_wcnt == 9'd1) ? DONE : CAPTURE;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Dropped words still count toward the burst so DONE arrives on time
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            r_wcnt     <= '0;
            r_tcnt     <= '0;
            r_overflow <= 1'b0;
        end else if (w_arm) begin
            r_wcnt     <= burst_words(burst_len_i);
            r_tcnt     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_busy && !abort_i && !w_timed_out)
                r_tcnt <= w_strobe ? '0 : r_tcnt + TW'(1);
            if (w_push)
                r_wcnt <= r_wcnt - 9'd1;
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign busy_o     = w_busy;
    assign done_o     = (r_state == DONE);
    assign timeout_o  = (r_state == ERROR);
    assign overflow_o = r_overflow;
    assign valid_o    = !w_empty;

    hbus_sync_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk90 (clk90),
        .rst   (rst),
        .flush (abort_i),
        .push  (w_push),
        .pop   (w_pop),
        .din   (dq_i),
        .dout  (dat_o),
        .full  (w_full),
        .empty (w_empty),
        .level (level_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_hbus_rd_capture.sv
`default_nettype none
// ============================================================================
// tb_hbus_rd_capture : directed self-checking bench            | rev 1.0
// ============================================================================
module tb_hbus_rd_capture;

    logic        clk90;
    logic        rst;
    logic        start_i;
    logic [7:0]  burst_len_i;
    logic        abort_i;
    logic [15:0] dq_i;
    logic [1:0]  rwds_i;
    logic [15:0] dat_o;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  level_o;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;
    logic        timeout_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    logic [15:0] popped [$];

    hbus_rd_capture #(
        .WIDTH         (8),
        .DEPTH         (8),
        .TIMEOUT_COUNT (15)
    ) dut (
        .clk90       (clk90),
        .rst         (rst),
        .start_i     (start_i),
        .burst_len_i (burst_len_i),
        .abort_i     (abort_i),
        .dq_i        (dq_i),
        .rwds_i      (rwds_i),
        .dat_o       (dat_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .timeout_o   (timeout_o)
    );

    initial clk90 = 1'b0;
    always #5 clk90 = ~clk90;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe at the falling edge, then drive inputs for the next rising edge
    task automatic tick(input logic st, input logic [7:0] len, input logic ab,
                        input logic [1:0] rw, input logic [15:0] d);
        if (valid_o && ready_i)
            popped.push_back(dat_o);
        if (done_o)
            n_done++;
        start_i     = st;
        burst_len_i = len;
        abort_i     = ab;
        rwds_i      = rw;
        dq_i        = d;
        @(negedge clk90);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_level"},    32'(level_o),    0);
        check_eq({tag, "_valid"},    32'(valid_o),    0);
        check_eq({tag, "_busy"},     32'(busy_o),     0);
        check_eq({tag, "_done"},     32'(done_o),     0);
        check_eq({tag, "_overflow"}, 32'(overflow_o), 0);
        check_eq({tag, "_timeout"},  32'(timeout_o),  0);
        check_eq({tag, "_dat"},      32'(dat_o),      0);
    endtask

    logic [1:0]  rw_seq [8] = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10};
    logic [15:0] exp2   [3] = '{16'hB000, 16'hB003, 16'hB005};

    initial begin
        rst = 1'b1; start_i = 1'b0; burst_len_i = 8'd0; abort_i = 1'b0;
        dq_i = 16'h0; rwds_i = 2'b00; ready_i = 1'b0;
        repeat (3) @(negedge clk90);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk90);

        // burst of 4, strobe every cycle, consumer always ready
        ready_i = 1'b1; popped.delete(); n_done = 0;
        tick(1'b1, 8'd4, 1'b0, 2'b00, 16'h0);
        check_eq("t1_busy", 32'(busy_o), 1);
        for (int i = 0; i < 4; i++) tick(1'b0, 8'd0, 1'b0, 2'b10, 16'(16'hA000 + i));
        repeat (3) tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t1_count", 32'(popped.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < popped.size()) check_eq("t1_word", 32'(popped[i]), 32'(16'hA000 + i));
        check_eq("t1_done", 32'(n_done), 1);
        check_eq("t1_level", 32'(level_o), 0);
        check_eq("t1_busy_end", 32'(busy_o), 0);

        // burst of 3 with non-strobe RWDS patterns interleaved
        popped.delete(); n_done = 0;
        tick(1'b1, 8'd3, 1'b0, 2'b00, 16'h0);
        for (int i = 0; i < 8; i++) tick(1'b0, 8'd0, 1'b0, rw_seq[i], 16'(16'hB000 + i));
        repeat (3) tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t2_count", 32'(popped.size()), 3);
        for (int i = 0; i < 3; i++)
            if (i < popped.size()) check_eq("t2_word", 32'(popped[i]), 32'(exp2[i]));
        check_eq("t2_done", 32'(n_done), 1);

        // burst of 10 into an 8-deep FIFO with no consumer
        ready_i = 1'b0; popped.delete(); n_done = 0;
        tick(1'b1, 8'd10, 1'b0, 2'b00, 16'h0);
        for (int i = 0; i < 10; i++) tick(1'b0, 8'd0, 1'b0, 2'b10, 16'(16'hC000 + i));
        repeat (3) tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t3_done", 32'(n_done), 1);
        check_eq("t3_level", 32'(level_o), 8);
        check_eq("t3_overflow", 32'(overflow_o), 1);
        check_eq("t3_head", 32'(dat_o), 32'h0000C000);
        ready_i = 1'b1;
        repeat (10) tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t3_count", 32'(popped.size()), 8);
        for (int i = 0; i < 8; i++)
            if (i < popped.size()) check_eq("t3_word", 32'(popped[i]), 32'(16'hC000 + i));
        check_eq("t3_level_end", 32'(level_o), 0);
        check_eq("t3_overflow_sticky", 32'(overflow_o), 1);

        // no strobes: timeout after 16 cycles, then re-arm from ERROR
        popped.delete(); n_done = 0;
        tick(1'b1, 8'd1, 1'b0, 2'b00, 16'h0);
        repeat (15) tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t4_timeout_early", 32'(timeout_o), 0);
        check_eq("t4_busy_early", 32'(busy_o), 1);
        tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t4_timeout", 32'(timeout_o), 1);
        check_eq("t4_busy", 32'(busy_o), 0);
        check_eq("t4_overflow_cleared", 32'(overflow_o), 0);
        repeat (3) tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t4_timeout_held", 32'(timeout_o), 1);
        tick(1'b1, 8'd1, 1'b0, 2'b00, 16'h0);
        check_eq("t4_rearm_timeout", 32'(timeout_o), 0);
        check_eq("t4_rearm_busy", 32'(busy_o), 1);
        tick(1'b0, 8'd0, 1'b0, 2'b10, 16'hD00D);
        repeat (3) tick(1'b0, 8'd0, 1'b0, 2'b00, 16'h0);
        check_eq("t4_done", 32'(n_done), 1);
        check_eq("t4_count", 32'(popped.size()), 1);
        if (popped.size() > 0) check_eq("t4_word", 32'(popped[0]), 32'h0000D00D);

        // abort after 2 of 6 strobes; a concurrent strobe must not be pushed
        ready_i = 1'b0; n_done = 0;
        tick(1'b1, 8'd6, 1'b0, 2'b00, 16'h0);
        tick(1'b0, 8'd0, 1'b0, 2'b10, 16'hE000);
        tick(1'b0, 8'd0, 1'b0, 2'b10, 16'hE001);
        check_eq("t5_level_pre", 32'(level_o), 2);
        check_eq("t5_valid_pre", 32'(valid_o), 1);
        tick(1'b0, 8'd0, 1'b1, 2'b10, 16'hE002);
        check_eq("t5_level", 32'(level_o), 0);
        check_eq("t5_valid", 32'(valid_o), 0);
        check_eq("t5_busy", 32'(busy_o), 0);
        check_eq("t5_dat", 32'(dat_o), 0);
        repeat (2) tick(1'b0, 8'd0, 1'b0, 2'b10, 16'hE003);
        check_eq("t5_idle_level", 32'(level_o), 0);
        check_eq("t5_done", 32'(n_done), 0);

        // reset in the middle of a capture
        tick(1'b1, 8'd5, 1'b0, 2'b00, 16'h0);
        tick(1'b0, 8'd0, 1'b0, 2'b10, 16'hF000);
        tick(1'b0, 8'd0, 1'b0, 2'b10, 16'hF001);
        check_eq("t6_busy_pre", 32'(busy_o), 1);
        rwds_i = 2'b10; dq_i = 16'hF002;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        @(negedge clk90);
        rst = 1'b0; n_done = 0;
        for (int i = 0; i < 4; i++) tick(1'b0, 8'd0, 1'b0, 2'b10, 16'(16'hF010 + i));
        check_eq("t6_done", 32'(n_done), 0);
        check_eq("t6_level", 32'(level_o), 0);
        check_eq("t6_busy", 32'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
